// File: rtl/dot_product_pkg.sv
// dot_product_pkg: shared state encoding and sizing helpers for the dot product engine
package dot_product_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WRITE} state_e;
  function automatic int acc_width(int dw, int aw, int pd);
    return 2 * dw + aw + $clog2(pd) + 1;
  endfunction
  function automatic int lane_lsb(int k, int dw);
    return k * dw;
  endfunction
endpackage

// File: rtl/dot_product_engine_lane_sum.sv
// dot_lane_sum: sum of the per-lane products of two packed SRAM words
module dot_lane_sum
  import dot_product_pkg::*;
#(
  parameter int Data_Width  = 8,
  parameter int Para_Deg    = 4,
  parameter int Signed_Mode = 0,
  localparam int SW = 2 * Data_Width + $clog2(Para_Deg) + 1
) (
  input  logic [Para_Deg*Data_Width-1:0] a_i,
  input  logic [Para_Deg*Data_Width-1:0] b_i,
  output logic [SW-1:0]                  sum_o
);
  logic signed [Data_Width:0] xa, xb;
  logic signed [SW-1:0] pa, pb;
  // one extra bit per lane lets a single signed multiplier serve both modes
  always_comb begin
    sum_o = '0;
    xa = '0;
    xb = '0;
    pa = '0;
    pb = '0;
    for (int k = 0; k < Para_Deg; k++) begin
      xa = {(Signed_Mode != 0) & a_i[lane_lsb(k, Data_Width) + Data_Width - 1], a_i[lane_lsb(k, Data_Width) +: Data_Width]};
      xb = {(Signed_Mode != 0) & b_i[lane_lsb(k, Data_Width) + Data_Width - 1], b_i[lane_lsb(k, Data_Width) +: Data_Width]};
      pa = SW'(xa);
      pb = SW'(xb);
      sum_o = sum_o + pa * pb;
    end
  end
endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: sequences two SRAM vector reads through a MAC and stores the scalar result
module dot_product_engine
  import dot_product_pkg::*;
#(
  parameter int Data_Width  = 8,
  parameter int Addr_Width  = 4,
  parameter int Ram_Depth   = 1 << Addr_Width,
  parameter int Para_Deg    = 4,
  parameter int Rd_Lat      = 1,
  parameter int Signed_Mode = 0,
  parameter int Acc_Width   = acc_width(Data_Width, Addr_Width, Para_Deg)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [Addr_Width:0]            len_i,
  input  logic [Addr_Width-1:0]          a_base_i,
  input  logic [Addr_Width-1:0]          b_base_i,
  input  logic [Addr_Width-1:0]          out_addr_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [Acc_Width-1:0]           result_o,
  output logic                           a_chip_select_o,
  output logic                           a_en_read_o,
  output logic [Addr_Width-1:0]          a_read_addr_o,
  input  logic [Para_Deg*Data_Width-1:0] a_read_data_i,
  output logic                           b_chip_select_o,
  output logic                           b_en_read_o,
  output logic [Addr_Width-1:0]          b_read_addr_o,
  input  logic [Para_Deg*Data_Width-1:0] b_read_data_i,
  output logic                           o_chip_select_o,
  output logic                           o_en_write_o,
  output logic [Addr_Width-1:0]          o_write_addr_o,
  output logic [Para_Deg*Data_Width-1:0] o_write_data_o
);
  localparam int WW = Para_Deg * Data_Width;
  localparam int SW = 2 * Data_Width + $clog2(Para_Deg) + 1;
  localparam logic [Addr_Width:0] DEPTH = (Addr_Width + 1)'(Ram_Depth);
  state_e state_q, state_d;
  logic [Addr_Width:0] len_q, len_d, idx_q, idx_d;
  logic [Addr_Width-1:0] a_base_q, a_base_d, b_base_q, b_base_d, out_addr_q, out_addr_d;
  logic [1:0] drn_q, drn_d;
  logic [Rd_Lat-1:0] vld_q;
  logic [Acc_Width-1:0] acc_q, acc_d, result_q, result_d, acc_ext;
  logic [SW-1:0] lane_sum;
  logic run, wr;
  dot_lane_sum #(.Data_Width(Data_Width), .Para_Deg(Para_Deg), .Signed_Mode(Signed_Mode)) u_lane_sum (
    .a_i(a_read_data_i), .b_i(b_read_data_i), .sum_o(lane_sum)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q <= '0;
      idx_q <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      out_addr_q <= '0;
      drn_q <= '0;
      vld_q <= '0;
      acc_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      idx_q <= idx_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      out_addr_q <= out_addr_d;
      drn_q <= drn_d;
      vld_q <= Rd_Lat'({vld_q, run});
      acc_q <= acc_d;
      result_q <= result_d;
    end
  end
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    out_addr_d = out_addr_q;
    drn_d = drn_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = (len_i == '0) ? WRITE : RUN;
        len_d = (len_i > DEPTH) ? DEPTH : len_i;
        idx_d = '0;
        a_base_d = a_base_i;
        b_base_d = b_base_i;
        out_addr_d = out_addr_i;
      end
      RUN: begin
        idx_d = idx_q + 1'b1;
        drn_d = '0;
        state_d = (idx_q == len_q - 1'b1) ? DRAIN : RUN;
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        state_d = (drn_q == 2'(Rd_Lat - 1)) ? WRITE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    run = state_q == RUN;
    wr = state_q == WRITE;
    acc_ext = (Signed_Mode != 0) ? Acc_Width'(signed'(lane_sum)) : Acc_Width'(lane_sum);
    acc_d = (state_q == IDLE && start_i) ? '0 : vld_q[Rd_Lat-1] ? acc_q + acc_ext : acc_q;
    result_d = wr ? acc_q : result_q;
  end
  assign busy_o = state_q != IDLE;
  assign done_o = wr;
  assign result_o = result_q;
  assign a_chip_select_o = run || state_q == DRAIN;
  assign b_chip_select_o = a_chip_select_o;
  assign a_en_read_o = run;
  assign b_en_read_o = run;
  assign a_read_addr_o = run ? a_base_q + idx_q[Addr_Width-1:0] : '0;
  assign b_read_addr_o = run ? b_base_q + idx_q[Addr_Width-1:0] : '0;
  assign o_chip_select_o = wr;
  assign o_en_write_o = wr;
  assign o_write_addr_o = wr ? out_addr_q : '0;
  assign o_write_data_o = !wr ? '0 : (Signed_Mode != 0) ? WW'(signed'(acc_q)) : WW'(acc_q);
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: random and directed runs of unsigned/Rd_Lat=1 and signed/Rd_Lat=2 engines against a vector model
module tb_dot_product_engine;
  logic clk = 0, rst_n, start, sel;
  logic [4:0] len;
  logic [3:0] ab, bb, oa;
  logic [31:0] mem_a [16], mem_b [16];
  logic busy0, done0, acs0, aen0, bcs0, ben0, ocs0, owe0, busy1, done1, acs1, aen1, bcs1, ben1, ocs1, owe1;
  logic [22:0] res0, res1;
  logic [3:0] aaddr0, baddr0, oaddr0, aaddr1, baddr1, oaddr1;
  logic [31:0] odata0, odata1, rda0, rdb0, rda1, rdb1, pa1, pb1;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rda0 <= mem_a[aaddr0];
    rdb0 <= mem_b[baddr0];
    pa1 <= mem_a[aaddr1];
    pb1 <= mem_b[baddr1];
    rda1 <= pa1;
    rdb1 <= pb1;
  end
  dot_product_engine u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start & ~sel), .len_i(len), .a_base_i(ab), .b_base_i(bb), .out_addr_i(oa),
    .busy_o(busy0), .done_o(done0), .result_o(res0),
    .a_chip_select_o(acs0), .a_en_read_o(aen0), .a_read_addr_o(aaddr0), .a_read_data_i(rda0),
    .b_chip_select_o(bcs0), .b_en_read_o(ben0), .b_read_addr_o(baddr0), .b_read_data_i(rdb0),
    .o_chip_select_o(ocs0), .o_en_write_o(owe0), .o_write_addr_o(oaddr0), .o_write_data_o(odata0));
  dot_product_engine #(.Rd_Lat(2), .Signed_Mode(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start & sel), .len_i(len), .a_base_i(ab), .b_base_i(bb), .out_addr_i(oa),
    .busy_o(busy1), .done_o(done1), .result_o(res1),
    .a_chip_select_o(acs1), .a_en_read_o(aen1), .a_read_addr_o(aaddr1), .a_read_data_i(rda1),
    .b_chip_select_o(bcs1), .b_en_read_o(ben1), .b_read_addr_o(baddr1), .b_read_data_i(rdb1),
    .o_chip_select_o(ocs1), .o_en_write_o(owe1), .o_write_addr_o(oaddr1), .o_write_data_o(odata1));
  wire busy_s = sel ? busy1 : busy0;
  wire done_s = sel ? done1 : done0;
  wire acs_s = sel ? acs1 : acs0;
  wire bcs_s = sel ? bcs1 : bcs0;
  wire aen_s = sel ? aen1 : aen0;
  wire ben_s = sel ? ben1 : ben0;
  wire ocs_s = sel ? ocs1 : ocs0;
  wire owe_s = sel ? owe1 : owe0;
  wire [3:0] aaddr_s = sel ? aaddr1 : aaddr0;
  wire [3:0] baddr_s = sel ? baddr1 : baddr0;
  wire [3:0] oaddr_s = sel ? oaddr1 : oaddr0;
  wire [31:0] odata_s = sel ? odata1 : odata0;
  wire [22:0] res_s = sel ? res1 : res0;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask
  function automatic longint ref_dot(int n, int a0, int b0, bit s);
    longint acc = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        longint x = longint'((mem_a[(a0 + i) % 16] >> (8 * k)) & 32'hFF);
        longint y = longint'((mem_b[(b0 + i) % 16] >> (8 * k)) & 32'hFF);
        if (s && x > 127) x -= 256;
        if (s && y > 127) y -= 256;
        acc += x * y;
      end
    return acc;
  endfunction
  task automatic fill(input logic [31:0] a, input logic [31:0] b, input bit rnd);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = rnd ? $urandom : a;
      mem_b[i] = rnd ? $urandom : b;
    end
  endtask
  task automatic run(input bit s, input int l, input int a0, input int b0, input int o0, input bit poke);
    int n = l > 16 ? 16 : l;
    int lat = s ? 2 : 1;
    int exp_done = n == 0 ? 1 : n + lat + 1;
    longint e = ref_dot(n, a0, b0, s);
    int dc = -1, bc = 0, csc = 0, am = 0, i = 0, wc = 0, wa = -1;
    longint wd = -1;
    @(negedge clk);
    sel = s; len = 5'(l); ab = 4'(a0); bb = 4'(b0); oa = 4'(o0); start = 1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(negedge clk);
      start = (poke && c == 2) ? 1'b1 : 1'b0;
      bc += int'(busy_s);
      csc += int'(acs_s && bcs_s);
      if (aen_s || ben_s) begin
        am += int'(!aen_s || !ben_s || aaddr_s != 4'((a0 + i) % 16) || baddr_s != 4'((b0 + i) % 16));
        i++;
      end
      if (owe_s || ocs_s) begin
        wc++;
        wa = int'(oaddr_s);
        wd = longint'(odata_s);
      end
      if (done_s) begin
        dc = c;
        if (poke) start = 1;
      end
    end
    if (dc < 0) chk("done_timeout", 0, 1);
    chk("done_cycle", dc, exp_done);
    chk("busy_cycles", bc, exp_done);
    chk("cs_cycles", csc, n == 0 ? 0 : n + lat);
    chk("issue_count", i, n);
    chk("addr_seq", am, 0);
    chk("write_count", wc, 1);
    chk("write_addr", wa, o0);
    chk("write_data", wd, e & 64'hFFFF_FFFF);
    @(negedge clk);
    start = 0;
    chk("result", longint'(res_s), e & 64'h7F_FFFF);
    chk("idle_after", longint'({busy_s, done_s}), 0);
  endtask
  initial begin
    int wc;
    rst_n = 0; start = 0; sel = 0; len = 0; ab = 0; bb = 0; oa = 0;
    fill(0, 0, 1);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_result", res0, 0);
    chk("rst_rd_en", aen0, 0);
    chk("rst_wr_en", owe0, 0);
    chk("rst_wdata", odata0, 0);
    rst_n = 1;
    fill(32'h01010101, 32'h02020202, 0);
    run(0, 4, 0, 0, 10, 0);
    fill(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run(0, 16, 0, 0, 3, 0);
    fill(0, 0, 1);
    run(0, 4, 14, 15, 7, 0);
    run(0, 0, 5, 5, 9, 0);
    @(negedge clk);
    sel = 0; len = 8; ab = 0; bb = 0; oa = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    chk("rst_mid_pre_en", aen0, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_rd", {acs0, aen0, aaddr0, bcs0, ben0, baddr0}, 0);
    chk("rst_mid_result", res0, 0);
    chk("rst_mid_wr", {ocs0, owe0, oaddr0, odata0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    wc = 0;
    repeat (14) begin
      @(negedge clk);
      wc += int'(owe0 || done0);
    end
    chk("rst_mid_no_write", wc, 0);
    fill(0, 0, 1);
    run(0, 2, 3, 9, 6, 0);
    fill(32'hFFFFFFFF, 32'h03030303, 0);
    run(1, 2, 0, 0, 4, 1);
    for (int t = 0; t < 14; t++) begin
      fill(0, 0, 1);
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Sequencer plus MAC datapath that computes the dot product of two Len-word vectors held in two Dual_SRAM instances (in1, in2). Each SRAM word carries Para_Deg lanes of Data_Width.
- Writes the scalar result into a third Dual_SRAM (out).
- Replaces testbench-driven SRAM sequencing with a hardware engine; generalised in lane count, vector length, read latency and signed/unsigned mode.

Parameters:
- Data_Width, 8, lane width in bits
- Addr_Width, 4, SRAM address width
- Ram_Depth, 1 << Addr_Width, words per SRAM
- Para_Deg, 4, lanes per SRAM word
- Rd_Lat, 1, SRAM read latency in cycles (1..3)
- Signed_Mode, 0, 0 = unsigned lanes, 1 = two's-complement lanes
- Acc_Width, 2*Data_Width + Addr_Width + clog2(Para_Deg) + 1, accumulator width; must be ≤ Para_Deg*Data_Width

Ports:
- clk  in  1  clock; all state changes on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  launch request, sampled only in IDLE
- Len  in  Addr_Width+1  vector length in words, 0..Ram_Depth
- A_Base  in  Addr_Width  first word address in in1 SRAM
- B_Base  in  Addr_Width  first word address in in2 SRAM
- Out_Addr  in  Addr_Width  result address in out SRAM
- Busy  out  1  high from the cycle after Start until Done inclusive
- Done  out  1  one-cycle completion pulse
- Result  out  Acc_Width  last result, held until next Done
- A_Chip_Select, A_En_Read  out  1 each  in1 SRAM control
- A_Read_Addr  out  Addr_Width  in1 SRAM address
- A_Read_Data  in  Para_Deg*Data_Width  in1 SRAM data
- B_Chip_Select, B_En_Read, B_Read_Addr, B_Read_Data  as above, for in2 SRAM
- O_Chip_Select, O_En_Write  out  1 each  out SRAM control
- O_Write_Addr  out  Addr_Width  out SRAM address
- O_Write_Data  out  Para_Deg*Data_Width  out SRAM data

Behaviour:
- Reset (async, Rst_n=0):
  - state IDLE; all outputs 0; accumulator 0; Result 0.
  - Reset mid-operation aborts immediately; no out-SRAM write occurs.
- States: IDLE, RUN, DRAIN, WRITE.
  - IDLE→RUN when Start=1 and Len≠0. Len, bases and Out_Addr are latched at this edge; accumulator is cleared.
  - IDLE→WRITE when Start=1 and Len=0; accumulator is cleared, so result = 0.
  - RUN: lasts exactly Len cycles. Issue index i (0..Len-1) in RUN cycle i.
    - A_En_Read = B_En_Read = 1.
    - A_Read_Addr = (A_Base+i) mod Ram_Depth; B likewise. Addresses wrap silently.
  - RUN→DRAIN after the last issue. DRAIN lasts Rd_Lat cycles.
  - DRAIN→WRITE.
  - WRITE: one cycle. O_En_Write=1, O_Write_Addr = latched Out_Addr, O_Write_Data = accumulator extended to Para_Deg*Data_Width (zero-extended if Signed_Mode=0, sign-extended if 1). Done=1; Result is loaded at the end of this cycle.
  - WRITE→IDLE.
- Chip selects: A_/B_Chip_Select high in RUN and DRAIN. O_Chip_Select high in WRITE only.
- Accumulation:
  - Data for issue i is valid Rd_Lat cycles after issue.
  - On that edge: acc += Σ lane products. Lane k = bits [k*Data_Width +: Data_Width]; each product is 2*Data_Width wide, signedness per Signed_Mode.
  - A valid-shift register of depth Rd_Lat tracks which cycles carry returning data.
- Latency: Start cycle = cycle 0. Done asserts in cycle Len+Rd_Lat+1 for Len>0, and in cycle 1 for Len=0.
- Start while Busy is ignored, with no queueing. Start in the same cycle as Done is ignored; it must be re-asserted in IDLE.
- Len > Ram_Depth is clamped to Ram_Depth.
- Overflow is impossible by sizing of Acc_Width. No saturation logic.

Decomposition:
- Package dot_product_pkg holds: state enum (IDLE/RUN/DRAIN/WRITE, 2-bit encoding), the Acc_Width derivation function, and the lane-slice helper.
- Sub-module dot_lane_sum: combinational Para_Deg multipliers plus adder tree with the Signed_Mode parameter; output width 2*Data_Width+clog2(Para_Deg)+1.
- The engine holds the FSM, address counters, valid pipe and accumulator.

Test Plan:
- Basic unsigned, defaults: every A lane = 1, every B lane = 2, A_Base=B_Base=0, Len=4, Out_Addr=10 → Done at cycle 6; out[10] = 32; Result = 32; Busy high cycles 1..6.
- Max values: all lanes 255, Len=16 → Result = 4161600; no overflow; out word = 32'h003F8040.
- Wrap-around: A_Base=14, B_Base=15, Len=4 → read addresses A 14,15,0,1 and B 15,0,1,2 observed; result matches the golden model.
- Len=0 → Done in cycle 1; out[Out_Addr] = 0; A_En_Read never asserted.
- Reset mid-operation: Rst_n low during RUN at i=2 → all outputs 0 immediately; O_En_Write never asserted; a later Start with Len=2 yields the correct result.
- Signed_Mode=1, Rd_Lat=2: A lanes = -1, B lanes = 3, Len=2 → Result = -24; O_Write_Data = 32'hFFFFFFE8; Done at cycle 5; Start pulsed during RUN is ignored.
